// File: rtl/ux607_regvec_pkg.sv
// Shared types and helpers for the register-vector write controller.
// Holds the FSM state encoding, the id width rule and the masked read-modify-write merge.
package ux607_regvec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 32;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits with mask=1 take the new data, the rest keep the current contents.
  function automatic logic [MAX_WIDTH-1:0] masked_merge(
    input logic [MAX_WIDTH-1:0] q,
    input logic [MAX_WIDTH-1:0] d,
    input logic [MAX_WIDTH-1:0] m
  );
    return (q & ~m) | (d & m);
  endfunction

endpackage

// File: rtl/ux607_rr_arb.sv
// Round-robin picker: first valid requester at or above ptr, wrapping; combinational, zero latency.
// Grant is suppressed while advance is low, so callers hold off grants when they cannot accept.
module ux607_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && j == cand && valid[j]) begin
          found    = 1'b1;
          idx      = IDW'(j);
          grant[j] = advance;
        end
      end
    end
  end

endmodule

// File: rtl/ux607_regvec_wr_arb.sv
// Arbitrated masked writer for one shared register vector: accept, write, read back; accept-to-rsp 2 cycles.
// One write in flight at a time; req_ready stays low outside IDLE, so requesters hold valid/data until accepted.
module ux607_regvec_wr_arb
  import ux607_regvec_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 3,
  parameter int IDW   = id_width(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  reg_en,
  input  logic [WIDTH-1:0]      reg_q,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_ok,
  output logic                  busy
);

  state_e               state;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       gid;
  logic [IDW-1:0]       gidx;
  logic [IDW-1:0]       ptr_next;
  logic [NREQ-1:0]      gnt;
  logic                 arb_go;
  logic [WIDTH-1:0]     exp_q;
  logic [WIDTH-1:0]     sel_data;
  logic [WIDTH-1:0]     sel_mask;
  logic [WIDTH-1:0]     merged;
  logic [MAX_WIDTH-1:0] merged_w;
  logic                 reg_en_q;
  logic                 rsp_vld_q;
  logic                 busy_q;

  // Grants only from IDLE and never in a reset cycle, so req_ready is 0 under reset.
  assign arb_go = (state == IDLE) && !reset;

  ux607_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arb (
    .valid   (req_valid),
    .ptr     (rr_ptr),
    .advance (arb_go),
    .grant   (gnt),
    .idx     (gidx)
  );

  always_comb begin
    sel_data = '0;
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDW'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mask = req_mask[i*WIDTH +: WIDTH];
      end
    end
  end

  assign merged_w = masked_merge(MAX_WIDTH'(reg_q), MAX_WIDTH'(sel_data), MAX_WIDTH'(sel_mask));
  assign merged   = merged_w[WIDTH-1:0];
  assign ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gid       <= '0;
      exp_q     <= '0;
      reg_en_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            gid      <= gidx;
            exp_q    <= merged;
            rr_ptr   <= ptr_next;
            reg_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          reg_en_q  <= 1'b0;
          rsp_vld_q <= 1'b1;
          state     <= CHECK;
        end
        CHECK: begin
          rsp_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          reg_en_q  <= 1'b0;
          rsp_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = gnt;
  assign reg_d     = exp_q;
  assign reg_en    = reg_en_q;
  // A reset landing in CHECK drops the response that would otherwise be reported.
  assign rsp_valid = rsp_vld_q && !reset;
  assign rsp_id    = gid;
  assign rsp_ok    = rsp_valid && (reg_q == exp_q);
  assign busy      = busy_q;

endmodule

// File: tb/tb_ux607_regvec_wr_arb.sv
// Self-checking bench for ux607_regvec_wr_arb with a behavioural register vector and a response scoreboard.
module tb_ux607_regvec_wr_arb;

  localparam int NREQ  = 2;
  localparam int WIDTH = 3;
  localparam int IDW   = 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*WIDTH-1:0] req_mask;
  logic [WIDTH-1:0]      reg_d;
  logic                  reg_en;
  logic [WIDTH-1:0]      reg_q;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_ok;
  logic                  busy;

  always #5 clock = ~clock;

  ux607_regvec_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .reg_d     (reg_d),
    .reg_en    (reg_en),
    .reg_q     (reg_q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_ok    (rsp_ok),
    .busy      (busy)
  );

  // Register vector model; stuck makes it ignore writes, preset loads it directly.
  logic [WIDTH-1:0] vec;
  logic             preset_en;
  logic [WIDTH-1:0] preset_val;
  logic             stuck;

  always @(posedge clock) begin
    if (preset_en) vec <= preset_val;
    else if (reg_en && !stuck) vec <= reg_d;
  end
  assign reg_q = vec;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] d;
    logic             ok;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   gcyc[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic saw_rsp;

  logic [NREQ-1:0]  s_req_ready;
  logic             s_reg_en;
  logic [WIDTH-1:0] s_reg_d;
  logic             s_rsp_valid;
  logic [IDW-1:0]   s_rsp_id;
  logic             s_rsp_ok;
  logic             s_busy;
  logic [WIDTH-1:0] s_vec;

  function automatic logic [WIDTH-1:0] model_merge(input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] m);
    return (q & ~m) | (d & m);
  endfunction

  // Samples at negedge, runs the scoreboard, then returns just after the next posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    cyc++;
    saw_rsp     = 1'b0;
    s_req_ready = req_ready;
    s_reg_en    = reg_en;
    s_reg_d     = reg_d;
    s_rsp_valid = rsp_valid;
    s_rsp_id    = rsp_id;
    s_rsp_ok    = rsp_ok;
    s_busy      = busy;
    s_vec       = vec;
    if (req_ready !== '0) begin
      n_tests++;
      if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
        n_fail++;
        $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          e.id  = i;
          e.d   = model_merge(vec, req_data[i*WIDTH +: WIDTH], req_mask[i*WIDTH +: WIDTH]);
          e.ok  = stuck ? (e.d == vec) : 1'b1;
          e.acc = cyc;
          sb.push_back(e);
          grants.push_back(i);
          gcyc.push_back(cyc);
        end
      end
    end
    if (reg_en === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: reg_en=1 reg_d=%b with no accepted request", reg_d);
      end else if (reg_d !== sb[0].d || cyc != sb[0].acc + 1) begin
        n_fail++;
        $display("FAIL write_data: reg_d=%b at cycle %0d, required %b at cycle %0d",
                 reg_d, cyc, sb[0].d, sb[0].acc + 1);
      end
    end
    if (rsp_valid === 1'b1) begin
      saw_rsp = 1'b1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=1 id=%0d ok=%b with nothing pending", rsp_id, rsp_ok);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== IDW'(e.id) || rsp_ok !== e.ok || cyc != e.acc + 2) begin
          n_fail++;
          $display("FAIL rsp_data: id=%0d ok=%b cycle=%0d, required id=%0d ok=%b cycle=%0d",
                   rsp_id, rsp_ok, cyc, e.id, e.ok, e.acc + 2);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    cycle();
    preset_en  = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!saw_rsp && n < budget);
    if (!saw_rsp) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_mask   = '0;
    stuck      = 1'b0;
    preset_en  = 1'b1;
    preset_val = '0;
    repeat (3) cycle();
    n_tests++;
    if ({s_req_ready, s_reg_en, s_reg_d, s_rsp_valid, s_rsp_id, s_rsp_ok, s_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b en=%b d=%b vld=%b id=%0d ok=%b busy=%b, required all 0",
               s_req_ready, s_reg_en, s_reg_d, s_rsp_valid, s_rsp_id, s_rsp_ok, s_busy);
    end
    preset_en = 1'b0;
    reset     = 1'b0;
    cycle();
  endtask

  task automatic test_single_write();
    preset(3'b000);
    req_data  = {3'b000, 3'b101};
    req_mask  = {3'b000, 3'b111};
    req_valid = 2'b01;
    cycle();
    n_tests++;
    if (s_req_ready !== 2'b01 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: ready=%b busy=%b, required 01 and 0", s_req_ready, s_busy);
    end
    req_valid = '0;
    cycle();
    n_tests++;
    if (s_reg_en !== 1'b1 || s_reg_d !== 3'b101 || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_write: en=%b d=%b busy=%b, required 1 101 1", s_reg_en, s_reg_d, s_busy);
    end
    cycle();
    n_tests++;
    if (s_rsp_valid !== 1'b1 || s_rsp_id !== 1'b0 || s_rsp_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rsp: vld=%b id=%0d ok=%b, required 1 0 1", s_rsp_valid, s_rsp_id, s_rsp_ok);
    end
    cycle();
    n_tests++;
    if (s_busy !== 1'b0 || s_vec !== 3'b101) begin
      n_fail++;
      $display("FAIL single_after: busy=%b vec=%b, required 0 101", s_busy, s_vec);
    end
  endtask

  task automatic test_masked_rmw();
    preset(3'b110);
    req_data  = {3'b001, 3'b000};
    req_mask  = {3'b011, 3'b000};
    req_valid = 2'b10;
    cycle();
    n_tests++;
    if (s_req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rmw_accept: ready=%b, required 10", s_req_ready);
    end
    req_valid = '0;
    cycle();
    n_tests++;
    if (s_reg_en !== 1'b1 || s_reg_d !== 3'b101) begin
      n_fail++;
      $display("FAIL rmw_write: en=%b d=%b, required 1 101", s_reg_en, s_reg_d);
    end
    cycle();
    n_tests++;
    if (s_rsp_valid !== 1'b1 || s_rsp_id !== 1'b1 || s_rsp_ok !== 1'b1 || s_vec !== 3'b101) begin
      n_fail++;
      $display("FAIL rmw_rsp: vld=%b id=%0d ok=%b vec=%b, required 1 1 1 101",
               s_rsp_valid, s_rsp_id, s_rsp_ok, s_vec);
    end
  endtask

  task automatic test_round_robin();
    int n;
    reset     = 1'b1;
    req_data  = {3'b100, 3'b010};
    req_mask  = {3'b110, 3'b111};
    req_valid = 2'b11;
    cycle();
    cycle();
    reset = 1'b0;
    sb.delete();
    grants.delete();
    gcyc.delete();
    n = 0;
    while (grants.size() < 8 && n < 40) begin
      cycle();
      n++;
    end
    req_valid = '0;
    n_tests++;
    if (grants.size() < 8) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants in 40 cycles, required 8", grants.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (grants[k] != (k % 2)) begin
          n_fail++;
          $display("FAIL rr_order: grant %0d went to %0d, required %0d", k, grants[k], k % 2);
        end
        if (k > 0) begin
          n_tests++;
          if (gcyc[k] - gcyc[k-1] != 3) begin
            n_fail++;
            $display("FAIL rr_spacing: grants %0d apart, required 3", gcyc[k] - gcyc[k-1]);
          end
        end
      end
    end
    wait_rsp(4);
  endtask

  task automatic test_readback_fail();
    stuck = 1'b1;
    preset(3'b000);
    req_data  = {3'b000, 3'b011};
    req_mask  = {3'b000, 3'b111};
    req_valid = 2'b01;
    cycle();
    req_valid = '0;
    wait_rsp(4);
    n_tests++;
    if (s_rsp_valid !== 1'b1 || s_rsp_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_fail: vld=%b ok=%b, required 1 0", s_rsp_valid, s_rsp_ok);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    req_data  = {3'b010, 3'b111};
    req_mask  = {3'b111, 3'b111};
    // Reset lands in WRITE: response is abandoned.
    req_valid = 2'b01;
    cycle();
    req_valid = '0;
    reset     = 1'b1;
    cycle();
    reset     = 1'b0;
    cycle();
    n_tests++;
    if (s_reg_en !== 1'b0 || s_busy !== 1'b0 || s_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_write: en=%b busy=%b vld=%b, required 0 0 0", s_reg_en, s_busy, s_rsp_valid);
    end
    sb.delete();
    bad = 0;
    repeat (3) begin
      cycle();
      if (s_rsp_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_rsp: %0d stray responses, required 0", bad);
    end
    req_valid = 2'b10;
    cycle();
    n_tests++;
    if (s_req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_req1: ready=%b, required 10", s_req_ready);
    end
    req_valid = '0;
    wait_rsp(4);
    // Reset lands in CHECK after a req0 grant moved the pointer to 1.
    req_valid = 2'b01;
    cycle();
    req_valid = '0;
    cycle();
    reset = 1'b1;
    cycle();
    n_tests++;
    if (s_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_check: rsp_valid=%b, required 0", s_rsp_valid);
    end
    reset = 1'b0;
    sb.delete();
    req_valid = 2'b11;
    cycle();
    n_tests++;
    if (s_req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_ptr: ready=%b, required 01", s_req_ready);
    end
    req_valid = '0;
    wait_rsp(4);
  endtask

  task automatic test_idle_zero_mask();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++;
      if (s_req_ready !== '0 || s_reg_en !== 1'b0 || s_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: cycle %0d ready=%b en=%b vld=%b, required 0", i, s_req_ready, s_reg_en, s_rsp_valid);
      end
    end
    preset(3'b110);
    req_data  = {3'b000, 3'b111};
    req_mask  = {3'b000, 3'b000};
    req_valid = 2'b01;
    cycle();
    req_valid = '0;
    cycle();
    n_tests++;
    if (s_reg_en !== 1'b1 || s_reg_d !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_mask_write: en=%b d=%b, required 1 110", s_reg_en, s_reg_d);
    end
    cycle();
    n_tests++;
    if (s_rsp_valid !== 1'b1 || s_rsp_ok !== 1'b1 || s_vec !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_mask_rsp: vld=%b ok=%b vec=%b, required 1 1 110", s_rsp_valid, s_rsp_ok, s_vec);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_masked_rmw();
    test_round_robin();
    test_readback_fail();
    test_reset_mid();
    test_idle_zero_mask();
    repeat (2) cycle();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
